// File: rtl/seq_divider_16_pkg.sv
// ============================================================================
// div_pkg : shared state encoding and defaults for the sequential divider
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    ITER   = 3'd4,
    DONE   = 3'd5
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_16_if.sv
// ============================================================================
// seq_divider_16_if : operand/result bus shared with the arithmetic sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_divider_16_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider_16_datapath.sv
// ============================================================================
// seq_div_datapath : R/Q/D registers, restoring shift-subtract step, results
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_a,
  input  wire logic             load_b,
  input  wire logic             check_en,
  input  wire logic             iter_en,
  input  wire logic [WIDTH-1:0] data_in,
  output logic      [WIDTH-1:0] quotient,
  output logic      [WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  cnt_one,
  output logic                  d_is_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;

  // Trial subtraction is one bit wider so its MSB is the borrow.
  always_comb begin
    w_shift    = {r_rem, r_q} << 1;
    w_trial    = {1'b0, w_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_d};
    w_rem_next = w_trial[WIDTH] ? w_shift[2*WIDTH-1:WIDTH] : w_trial[WIDTH-1:0];
    w_q_next   = {w_shift[WIDTH-1:1], ~w_trial[WIDTH]};
  end

  assign cnt_one   = (r_cnt == CW'(1));
  assign d_is_zero = (r_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load_a) begin
        r_q         <= data_in;
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
      if (load_b) r_d <= data_in;
      if (check_en) begin
        if (d_is_zero) begin
          quotient    <= '1;
          remainder   <= r_q;
          div_by_zero <= 1'b1;
        end else begin
          r_rem       <= '0;
          r_cnt       <= CW'(WIDTH);
          div_by_zero <= 1'b0;
        end
      end
      if (iter_en) begin
        r_rem <= w_rem_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt - CW'(1);
        // Final step publishes the results as the FSM enters DONE.
        if (cnt_one) begin
          quotient  <= w_q_next;
          remainder <= w_rem_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider_16.sv
// ============================================================================
// seq_divider_16 : sequential unsigned restoring divider, one quotient bit/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider_16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input wire logic         clk,
  input wire logic         rst_n,
  seq_divider_16_if.slave  bus
);

  div_state_t       r_state;
  div_state_t       w_next;
  logic             w_cnt_one;
  logic             w_d_is_zero;
  logic [WIDTH-1:0] w_quotient;
  logic [WIDTH-1:0] w_remainder;
  logic             w_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // start is only looked at in IDLE and DONE, so a level held through busy is harmless.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LOAD_A;
      LOAD_A:  w_next = LOAD_B;
      LOAD_B:  w_next = CHECK;
      CHECK:   w_next = w_d_is_zero ? DONE : ITER;
      ITER:    if (w_cnt_one) w_next = DONE;
      DONE:    if (!bus.start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  seq_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_a      (r_state == LOAD_A),
    .load_b      (r_state == LOAD_B),
    .check_en    (r_state == CHECK),
    .iter_en     (r_state == ITER),
    .data_in     (bus.data_in),
    .quotient    (w_quotient),
    .remainder   (w_remainder),
    .div_by_zero (w_dbz),
    .cnt_one     (w_cnt_one),
    .d_is_zero   (w_d_is_zero)
  );

  assign bus.quotient    = w_quotient;
  assign bus.remainder   = w_remainder;
  assign bus.div_by_zero = w_dbz;
  assign bus.done        = (r_state == DONE);
  assign bus.busy        = (r_state == LOAD_A) || (r_state == LOAD_B) ||
                           (r_state == CHECK)  || (r_state == ITER);

endmodule

`default_nettype wire
